parity_frame_rx: RTL
====================

// Module: parity_frame_rx
// PURPOSE
//  Bit-serial frame receiver and parity checker: receiving end of the XOR parity link.
//  Frame format: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
//  Deserialises the data and recomputes parity with an XOR accumulator.
//  Delivers one parallel word per frame, flagged with parity/framing status. Sits between a serial line sampler and word-level consumers.
// PARAMETERS
//  DATA_W      8    data bits per frame (1..32)
//  PARITY_ODD  0    0 = even parity (XOR of data+parity == 0), 1 = odd (== 1)
//  TIMEOUT     16   max clk cycles between bit_valid strobes inside a frame (>=2)
// PORTS
//  clk         in   1       single clock, all logic on rising edge
//  rst         in   1       synchronous, active-high reset
//  bit_in      in   1       serial data bit, sampled only when bit_valid=1
//  bit_valid   in   1       strobe: bit_in holds one frame bit this cycle
//  data_out    out  DATA_W  received word, held stable until next data_valid
//  data_valid  out  1       1-cycle pulse: data_out updated, frame closed with stop=1
//  parity_err  out  1       qualified by data_valid: 1 = parity mismatch
//  frame_err   out  1       1-cycle pulse: bad stop bit or inter-bit timeout; no data_valid
//  busy        out  1       1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//  Bit counter and XOR accumulator cleared. Reset mid-frame discards the partial frame silently.
//  FSM (advances only on bit_valid, except timeout):
//   IDLE:   bit_valid&bit_in=0 -> DATA, clear cnt/acc; bit_in=1 ignored (line idle)
//   DATA:   bit_valid -> shift bit_in into shreg[cnt] (LSB first), acc^=bit_in, cnt++;
//           the DATA_W-th bit -> PARITY
//   PARITY: bit_valid -> acc^=bit_in -> STOP
//   STOP:   bit_valid&bit_in=1 -> data_out<=shreg, data_valid=1,
//           parity_err=(acc!=PARITY_ODD) -> IDLE
//           bit_valid&bit_in=0 -> frame_err=1, data_out unchanged -> IDLE
//  Latency: outputs are registered and appear in the cycle after the edge that samples the stop bit.
//  Timeout: tcnt counts clk cycles without bit_valid while state!=IDLE; cleared on each bit_valid.
//   When tcnt reaches TIMEOUT: frame_err=1, -> IDLE, partial data discarded.
//   tcnt is held at 0 in IDLE.
//  Back-to-back: a start bit (0) on the cycle right after the stop bit is accepted; no idle gap is required.
//  bit_valid on the same cycle as a timeout expiry: the bit wins, tcnt clears, no frame_err.
//  data_valid and frame_err are never high together. parity_err=0 whenever data_valid=0.
//  Widths: cnt is $clog2(DATA_W+1) bits; tcnt is $clog2(TIMEOUT+1) bits; no wrap inside a frame.
// STRUCTURE
//  Shared package serial_pkg:
//   state encoding (IDLE/DATA/PARITY/STOP, 2 bits)
//   START_BIT=1'b0, STOP_BIT=1'b1
//   function parity_of(vector) used by the generator and this checker
//  Sub-module frame_timeout:
//   inputs clk, rst, enable(busy), kick(bit_valid); output expired; parameter TIMEOUT
//  FSM, shift register and XOR accumulator stay in this module.
// TESTING
//  1 DATA_W=8 even: bits 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1)
//    -> data_valid 1 cycle, data_out=8'hA5, parity_err=0, frame_err=0
//  2 Same frame with parity bit 1 -> data_valid=1, data_out=8'hA5, parity_err=1
//  3 0xA5 frame with stop bit 0 -> frame_err pulse, no data_valid, data_out holds previous value
//  4 Start + 3 data bits, then bit_valid low for TIMEOUT=16 cycles
//    -> frame_err on the timeout cycle, busy falls; the next full 0x3C frame is received cleanly
//  5 Two frames back-to-back, 0x01 then 0xFF, no idle gap -> two data_valid pulses, values 0x01 then 0xFF, parity_err=0 both
//  6 rst=1 asserted mid-DATA -> all outputs 0 next cycle; the following 0x5A frame is received correctly

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the XOR parity serial link.
// Used by both the frame generator and the frame receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic parity_of(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-bit watchdog: counts idle clocks while a frame is open.
// A kick on the expiry cycle wins, so expired stays low then.
module frame_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tcnt;

    always_ff @(posedge clk) begin
        if (rst || !enable || kick) begin
            r_tcnt <= '0;
        end else if (r_tcnt != TW'(TIMEOUT)) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end

    // Fires on the TIMEOUT-th consecutive idle clock.
    assign expired = enable && !kick && (r_tcnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/parity_frame_rx.sv
// Bit-serial frame receiver: start, DATA_W bits LSB first, parity, stop.
// Emits one registered word per frame with parity and framing status.
module parity_frame_rx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MSB_ONE = DATA_W'(1) << (DATA_W - 1);

    rx_state_t         r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_acc, w_acc_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic [DATA_W-1:0] r_dout, w_dout_nxt;
    logic              r_dv, w_dv_nxt;
    logic              r_pe, w_pe_nxt;
    logic              r_fe, w_fe_nxt;
    logic              w_busy;
    logic              w_expired;

    assign w_busy = (r_state != S_IDLE);

    frame_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_busy),
        .kick    (bit_valid),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
            r_shreg <= '0;
            r_dout  <= '0;
            r_dv    <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_shreg <= w_shreg_nxt;
            r_dout  <= w_dout_nxt;
            r_dv    <= w_dv_nxt;
            r_pe    <= w_pe_nxt;
            r_fe    <= w_fe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_shreg_nxt = r_shreg;
        w_dout_nxt  = r_dout;
        w_dv_nxt    = 1'b0;
        w_pe_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bit_valid && bit_in == START_BIT) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = '0;
                    w_acc_nxt   = 1'b0;
                end
            end
            S_DATA: begin
                if (bit_valid) begin
                    // Shift in from the top so the first bit lands in bit 0.
                    w_shreg_nxt = (r_shreg >> 1) | (bit_in ? MSB_ONE : '0);
                    w_acc_nxt   = r_acc ^ bit_in;
                    w_cnt_nxt   = r_cnt + CW'(1);
                    if (r_cnt == CW'(DATA_W - 1)) begin
                        w_state_nxt = S_PARITY;
                    end
                end else if (w_expired) begin
                    w_state_nxt = S_IDLE;
                    w_fe_nxt    = 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_valid) begin
                    w_acc_nxt   = r_acc ^ bit_in;
                    w_state_nxt = S_STOP;
                end else if (w_expired) begin
                    w_state_nxt = S_IDLE;
                    w_fe_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_valid) begin
                    w_state_nxt = S_IDLE;
                    if (bit_in == STOP_BIT) begin
                        w_dout_nxt = r_shreg;
                        w_dv_nxt   = 1'b1;
                        w_pe_nxt   = (r_acc != PARITY_ODD);
                    end else begin
                        w_fe_nxt = 1'b1;
                    end
                end else if (w_expired) begin
                    w_state_nxt = S_IDLE;
                    w_fe_nxt    = 1'b1;
                end
            end
        endcase
    end

    assign data_out   = r_dout;
    assign data_valid = r_dv;
    assign parity_err = r_pe;
    assign frame_err  = r_fe;
    assign busy       = w_busy;

endmodule
